// File: rtl/wfg_pat_decode_channel.sv
// wfg_pat_decode_channel
// Decodes one waveform-generator pattern channel (RZ / RO / NRZ / RC) back
// into DATA_WIDTH-bit words. The data level is captured at a configurable
// subcycle of every bit cycle. The return level is checked at another
// configurable subcycle. Completed words go out over an AXI-Stream style
// register stage, with sticky pattern-error and overflow flags.
//
// Optional build macro: WFG_PAT_DECODE_SYNC_EN
//   defined   -> data_i passes through a two-flop synchronizer (2-cycle latency).
//   undefined -> data_i is used directly and must be synchronous to clk.
module wfg_pat_decode_channel #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wfg_core_subcycle_cnt_i,
    input  logic [1:0]            patsel_q_i,
    input  logic [7:0]            cfg_sample_q_i,
    input  logic [7:0]            cfg_check_q_i,
    input  logic                  ctrl_en_q_i,
    input  logic                  err_clr_i,
    input  logic                  data_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  err_pat_o,
    output logic                  err_ovf_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;

    localparam logic [1:0] PAT_RZ  = 2'b00;
    localparam logic [1:0] PAT_RO  = 2'b01;
    localparam logic [1:0] PAT_NRZ = 2'b10;

    logic                  line_lvl;
    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [CW-1:0]         bit_cnt_reg;
    // The last bit of a word is never stored here; it comes straight from the line.
    logic [DATA_WIDTH-2:0] shift_reg;
    logic                  last_bit_reg;
    logic                  word_done_reg;
    logic [DATA_WIDTH-1:0] done_word_reg;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic                  tvalid_reg;
    logic                  err_pat_reg;
    logic                  err_ovf_reg;

    logic capture;
    logic check_evt;
    logic expected_lvl;
    logic pat_mismatch;
    logic word_last;
    logic handshake;
    logic ovf_event;

`ifdef WFG_PAT_DECODE_SYNC_EN
    logic sync_meta_reg;
    logic sync_line_reg;

    // Two-flop synchronizer bringing the asynchronous line into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= 1'b0;
            sync_line_reg <= 1'b0;
        end else begin
            sync_meta_reg <= data_i;
            sync_line_reg <= sync_meta_reg;
        end
    end

    assign line_lvl = sync_line_reg;
`else
    assign line_lvl = data_i;
`endif

    // Sample and check strobes. When both point at the same subcycle, only the capture happens.
    always_comb begin
        capture   = (state_reg == ST_COLLECT) && (wfg_core_subcycle_cnt_i == cfg_sample_q_i);
        check_evt = (state_reg == ST_COLLECT) && (wfg_core_subcycle_cnt_i == cfg_check_q_i)
                    && (cfg_check_q_i != cfg_sample_q_i);
        case (patsel_q_i)
            PAT_RZ:  expected_lvl = 1'b0;
            PAT_RO:  expected_lvl = 1'b1;
            PAT_NRZ: expected_lvl = last_bit_reg;
            default: expected_lvl = ~last_bit_reg;
        endcase
        pat_mismatch = check_evt && (line_lvl != expected_lvl);
        word_last    = capture && (bit_cnt_reg == LAST_BIT);
        handshake    = tvalid_reg && m_axis_tready_i;
        ovf_event    = word_done_reg && tvalid_reg && !m_axis_tready_i;
    end

    // Next-state logic: a low enable drops any state back to IDLE
    always_comb begin
        state_next = state_reg;
        if (!ctrl_en_q_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_ARMED;
                ST_ARMED: if (wfg_core_subcycle_cnt_i == 8'd0) state_next = ST_COLLECT;
                default:  state_next = ST_COLLECT;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bit counter and last-captured-bit tracking; both are cleared while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg  <= '0;
            last_bit_reg <= 1'b0;
        end else if (!ctrl_en_q_i) begin
            bit_cnt_reg  <= '0;
            last_bit_reg <= 1'b0;
        end else if (capture) begin
            bit_cnt_reg  <= word_last ? '0 : bit_cnt_reg + 1'b1;
            last_bit_reg <= line_lvl;
        end
    end

    // Per-bit slots of the partial word. Slot k is written by the k-th capture (LSB first).
    for (genvar gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shift_reg[gi] <= 1'b0;
            end else if (!ctrl_en_q_i) begin
                shift_reg[gi] <= 1'b0;
            end else if (capture && (bit_cnt_reg == CW'(gi))) begin
                shift_reg[gi] <= line_lvl;
            end
        end
    end

    // Stage a completed word for one cycle before it reaches the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_done_reg <= 1'b0;
            done_word_reg <= '0;
        end else begin
            word_done_reg <= word_last;
            if (word_last) begin
                done_word_reg <= {line_lvl, shift_reg};
            end
        end
    end

    // Output register: load when empty or being accepted; otherwise the new word is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
        end else if (word_done_reg && (!tvalid_reg || handshake)) begin
            tdata_reg  <= done_word_reg;
            tvalid_reg <= 1'b1;
        end else if (handshake) begin
            tvalid_reg <= 1'b0;
        end
    end

    // Sticky error flags: a set event in the same cycle overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pat_reg <= 1'b0;
            err_ovf_reg <= 1'b0;
        end else begin
            if (pat_mismatch) begin
                err_pat_reg <= 1'b1;
            end else if (err_clr_i) begin
                err_pat_reg <= 1'b0;
            end
            if (ovf_event) begin
                err_ovf_reg <= 1'b1;
            end else if (err_clr_i) begin
                err_ovf_reg <= 1'b0;
            end
        end
    end

    assign m_axis_tdata_o  = tdata_reg;
    assign m_axis_tvalid_o = tvalid_reg;
    assign err_pat_o       = err_pat_reg;
    assign err_ovf_o       = err_ovf_reg;

endmodule

// File: tb/tb_wfg_pat_decode_channel.sv
// tb_wfg_pat_decode_channel
// Directed scenarios plus randomized traffic, checked every cycle against a
// word/queue-level reference model of the decode channel (default build).
module tb_wfg_pat_decode_channel;

    localparam int DW  = 8;
    localparam int PER = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    cnt;
    logic [1:0]    patsel;
    logic [7:0]    sample;
    logic [7:0]    check;
    logic          en;
    logic          clr;
    logic          data;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          err_pat;
    logic          err_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_state;      // 0 idle, 1 armed, 2 collecting
    bit            m_bits[$];
    bit            m_last;
    bit            m_pend;
    bit [DW-1:0]   m_pend_word;
    bit            m_valid;
    bit [DW-1:0]   m_data;
    bit            m_epat;
    bit            m_eovf;

    wfg_pat_decode_channel #(.DATA_WIDTH(DW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .wfg_core_subcycle_cnt_i (cnt),
        .patsel_q_i              (patsel),
        .cfg_sample_q_i          (sample),
        .cfg_check_q_i           (check),
        .ctrl_en_q_i             (en),
        .err_clr_i               (clr),
        .data_i                  (data),
        .m_axis_tdata_o          (tdata),
        .m_axis_tvalid_o         (tvalid),
        .m_axis_tready_i         (tready),
        .err_pat_o               (err_pat),
        .err_ovf_o               (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_bits.delete();
        m_last = 0; m_pend = 0; m_pend_word = '0;
        m_valid = 0; m_data = '0; m_epat = 0; m_eovf = 0;
    endtask

    function automatic bit ret_level(input logic [1:0] p, input bit b);
        case (p)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return b;
            default: return ~b;
        endcase
    endfunction

    // Effect of the coming rising edge given the inputs currently applied
    task automatic model_step();
        bit line, hs, ovf_set, pat_set, exp;
        line = data;
        hs = m_valid && tready;
        ovf_set = 0;
        pat_set = 0;
        if (m_pend) begin
            if (!m_valid || hs) begin
                m_data  = m_pend_word;
                m_valid = 1;
            end else begin
                ovf_set = 1;
            end
        end else if (hs) begin
            m_valid = 0;
        end
        m_pend = 0;
        if (m_state == 2) begin
            if (cnt == sample) begin
                m_bits.push_back(line);
                m_last = line;
                if (m_bits.size() == DW) begin
                    m_pend = 1;
                    for (int k = 0; k < DW; k++) m_pend_word[k] = m_bits[k];
                    m_bits.delete();
                end
            end else if (cnt == check) begin
                exp = ret_level(patsel, m_last);
                if (line != exp) pat_set = 1;
            end
        end
        m_epat = pat_set ? 1'b1 : (clr ? 1'b0 : m_epat);
        m_eovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_eovf);
        if (!en) begin
            m_bits.delete();
            m_last  = 0;
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && cnt == 8'd0) begin
            m_state = 2;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cnt = 8'((int'(cnt) + 1) % PER);
        check_val("tvalid", 32'(tvalid), 32'(m_valid));
        check_val("tdata", 32'(tdata), 32'(m_data));
        check_val("err_pat", 32'(err_pat), 32'(m_epat));
        check_val("err_ovf", 32'(err_ovf), 32'(m_eovf));
    endtask

    task automatic align();
        for (int i = 0; i < PER && cnt != 8'd0; i++) tick();
    endtask

    // One bit cycle: data level until subcycle 5, return level afterwards
    task automatic send_bit(input bit b, input bit corrupt);
        for (int i = 0; i < PER; i++) begin
            data = (cnt < 8'd5) ? b : (ret_level(patsel, b) ^ corrupt);
            tick();
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        logic [DW-1:0] wv;
        wv = w;
        for (int k = 0; k < DW; k++) send_bit(wv[k], 1'b0);
    endtask

    task automatic restart(input logic [1:0] p);
        en = 0;
        tick(); tick();
        patsel = p;
        en = 1;
        tick();
        align();
    endtask

    task automatic drain();
        tready = 1; tick(); tready = 0;
    endtask

    task automatic pulse_clr();
        clr = 1; tick(); clr = 0;
    endtask

    initial begin
        logic [7:0] w;
        bit cur_b;
        rst = 1; cnt = 0; patsel = 2'b10; sample = 8'd4; check = 8'd6;
        en = 0; clr = 0; data = 0; tready = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_val("rst_tvalid", 32'(tvalid), 32'd0);
        check_val("rst_tdata", 32'(tdata), 32'd0);
        check_val("rst_err_pat", 32'(err_pat), 32'd0);
        check_val("rst_err_ovf", 32'(err_ovf), 32'd0);
        rst = 0;

        // NRZ word 0x4D
        restart(2'b10);
        send_word(8'h4D);
        check_val("nrz_tdata", 32'(tdata), 32'h4D);
        check_val("nrz_tvalid", 32'(tvalid), 32'd1);
        check_val("nrz_err_pat", 32'(err_pat), 32'd0);
        drain();
        check_val("nrz_accept", 32'(tvalid), 32'd0);

        // RZ with a bad return level in bit 3
        restart(2'b00);
        w = 8'h5A;
        for (int k = 0; k < DW; k++) begin
            send_bit(w[k], k == 3);
            if (k == 2) check_val("rz_pre_err", 32'(err_pat), 32'd0);
            if (k >= 3) check_val("rz_err_sticky", 32'(err_pat), 32'd1);
        end
        check_val("rz_tdata", 32'(tdata), 32'h5A);
        pulse_clr();
        check_val("rz_err_clr", 32'(err_pat), 32'd0);
        drain();

        // RC word 0xA5 clean, then one non-inverted return
        restart(2'b11);
        send_word(8'hA5);
        check_val("rc_tdata", 32'(tdata), 32'hA5);
        check_val("rc_err_pat", 32'(err_pat), 32'd0);
        drain();
        send_bit(1'b1, 1'b1);
        check_val("rc_bad_return", 32'(err_pat), 32'd1);
        pulse_clr();

        // Overflow: two words while tready is low
        restart(2'b10);
        send_word(8'h11);
        send_word(8'h22);
        check_val("ovf_tdata", 32'(tdata), 32'h11);
        check_val("ovf_flag", 32'(err_ovf), 32'd1);
        check_val("ovf_tvalid", 32'(tvalid), 32'd1);
        drain();
        check_val("ovf_accept", 32'(tvalid), 32'd0);
        pulse_clr();
        check_val("ovf_clr", 32'(err_ovf), 32'd0);

        // Enable mid bit-cycle, partial word then disable, re-enable
        en = 0;
        tick();
        for (int i = 0; i < PER && cnt != 8'd5; i++) tick();
        patsel = 2'b10; en = 1; data = 1;
        align();
        check_val("late_en_no_word", 32'(tvalid), 32'd0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        en = 0;
        tick(); tick(); tick();
        en = 1;
        tick();
        align();
        send_word(8'h3C);
        check_val("reenable_tdata", 32'(tdata), 32'h3C);
        drain();

        // Randomized traffic: random line, tready, clears, enable drops, sample/check
        for (int phase = 0; phase < 4; phase++) begin
            patsel = 2'($urandom_range(0, 3));
            sample = 8'($urandom_range(0, PER - 1));
            check  = (phase == 2) ? sample : 8'($urandom_range(0, PER - 1));
            cur_b  = 0;
            for (int c = 0; c < 600; c++) begin
                if (cnt == 8'd0) cur_b = 1'($urandom);
                if ($urandom_range(0, 3) == 0) data = 1'($urandom);
                else data = (cnt < 8'd5) ? cur_b : ret_level(patsel, cur_b);
                tready = ($urandom_range(0, 2) != 0);
                clr    = ($urandom_range(0, 30) == 0);
                if ($urandom_range(0, 150) == 0) en = 0;
                else if (!en && $urandom_range(0, 3) == 0) en = 1;
                tick();
            end
            clr = 0; tready = 0;
        end

        // Asynchronous reset mid-word with a word held in the output register
        pulse_clr();
        restart(2'b10);
        send_word(8'h77);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        check_val("pre_rst_tvalid", 32'(tvalid), 32'd1);
        #2 rst = 1;
        #1;
        check_val("arst_tvalid", 32'(tvalid), 32'd0);
        check_val("arst_tdata", 32'(tdata), 32'd0);
        check_val("arst_err_pat", 32'(err_pat), 32'd0);
        check_val("arst_err_ovf", 32'(err_ovf), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        cnt = 8'((int'(cnt) + 1) % PER);
        for (int i = 0; i < 3 * PER; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wfg_pat_decode_channel.md
WFG_PAT_DECODE_CHANNEL -- requirements
Module: wfg_pat_decode_channel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: decoded bits per output word, legal 2..32.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wfg_core_subcycle_cnt_i  input  8  core subcycle counter; value 0 marks a bit-cycle start.
REQ-005 SHALL have port patsel_q_i  input  2  pattern: 00 RZ, 01 RO, 10 NRZ, 11 RC.
REQ-006 SHALL have port cfg_sample_q_i  input  8  subcycle at which the data level is captured.
REQ-007 SHALL have port cfg_check_q_i  input  8  subcycle at which the return level is checked.
REQ-008 SHALL have port ctrl_en_q_i  input  1  channel enable.
REQ-009 SHALL have port err_clr_i  input  1  single-cycle pulse, clears sticky flags.
REQ-010 SHALL have port data_i  input  1  asynchronous line input.
REQ-011 SHALL have port m_axis_tdata_o  output  DATA_WIDTH  decoded word.
REQ-012 SHALL have port m_axis_tvalid_o  output  1  word valid.
REQ-013 SHALL have port m_axis_tready_i  input  1  downstream accept.
REQ-014 SHALL have port err_pat_o  output  1  sticky return-level mismatch.
REQ-015 SHALL have port err_ovf_o  output  1  sticky word-drop overflow.

Function
REQ-016 SHALL implement FSM states IDLE, ARMED, COLLECT; IDLE->ARMED when ctrl_en_q_i=1; ARMED->COLLECT in the cycle subcycle_cnt==0; any state->IDLE the cycle after ctrl_en_q_i=0.
REQ-017 SHALL, in COLLECT when subcycle_cnt==cfg_sample_q_i, capture the line level (line = conditioned data_i, REQ-030) as the next decoded bit for all four patterns.
REQ-018 SHALL place decoded bits LSB first: bit k of a word is the k-th capture; bit counter wraps DATA_WIDTH-1 -> 0.
REQ-019 SHALL, in COLLECT when subcycle_cnt==cfg_check_q_i, compare line to expected: RZ 0, RO 1, NRZ last captured bit, RC inverse of last captured bit; mismatch sets err_pat_o.
REQ-020 SHALL skip the check when cfg_check_q_i==cfg_sample_q_i; capture takes priority.
REQ-021 SHALL, on capture of bit DATA_WIDTH-1, transfer the full word to the output register one cycle later with m_axis_tvalid_o=1.
REQ-022 SHALL hold m_axis_tdata_o/m_axis_tvalid_o stable until m_axis_tvalid_o&&m_axis_tready_i, then drop tvalid next cycle.
REQ-023 SHALL, if a word completes while tvalid=1 and tready=0, drop the new word, keep the held word, set err_ovf_o.
REQ-024 SHALL, if a word completes in the same cycle as a handshake, load the new word with tvalid remaining 1, no overflow.
REQ-025 SHALL, on entry to IDLE, clear bit counter and shift register; a pending output word is retained until accepted.
REQ-026 SHALL clear err_pat_o and err_ovf_o on err_clr_i; a set event in the same cycle wins.
REQ-027 SHALL not raise err_pat_o in IDLE or ARMED.

Reset
REQ-028 SHALL, on rst=1, asynchronously force: FSM IDLE, counter 0, shift register 0, m_axis_tdata_o 0, m_axis_tvalid_o 0, err_pat_o 0, err_ovf_o 0, synchronizer flops 0.
REQ-029 SHALL, on reset mid-word, discard the partial word and pending output without asserting any flag.

Configuration
REQ-030 SHALL with WFG_PAT_DECODE_SYNC_EN defined use a two-flop synchronizer on data_i as line (2-cycle latency; cfg_sample/check refer to line timing); without it SHALL use data_i directly as line (0 latency, input must be clk-synchronous).

Verification
REQ-031 SHALL cover: NRZ, DATA_WIDTH=8, sample=4, check=6, bits 1,0,1,1,0,0,1,0 driven -> tdata=8'h4D, tvalid=1, err_pat_o=0.
REQ-032 SHALL cover: RZ, line high at check subcycle in bit 3 -> err_pat_o=1 from next cycle, stays 1 until err_clr_i pulse.
REQ-033 SHALL cover: RC, bits 0xA5 with correct inverse return -> tdata=8'hA5, no error; force non-inverted return once -> err_pat_o=1.
REQ-034 SHALL cover: tready=0 across two complete words 0x11, 0x22 -> tdata stays 0x11, err_ovf_o=1; tready=1 -> 0x11 accepted, tvalid drops.
REQ-035 SHALL cover: enable at subcycle 5 -> no capture until subcycle 0; disable after 3 bits then re-enable -> next word contains only new bits.
REQ-036 SHALL cover: rst=1 pulse mid-word with tvalid=1 -> all outputs 0 immediately, no flag set.
